// File: rtl/rps_rr_arbiter.sv
// Round-robin arbiter with rotating priority pointer and a grant that stays locked until the owner releases it.
// Latency: one cycle from request to registered grant. A release hands off on the same edge, with no idle cycle.
// Backpressure: none; en=0 drops the grant. Optional macro RPS_HOLD_TIMEOUT_EN forces rotation after MAX_HOLD cycles.
module rps_rr_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int IDX_W    = $clog2(NUM_REQ),
  parameter int MAX_HOLD = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid,
  output logic               req_up
);

  // Reject illegal configurations at elaboration time.
  if ((NUM_REQ < 2) || ((NUM_REQ & (NUM_REQ - 1)) != 0) || (MAX_HOLD < 1)) begin : g_param_check
    $error("rps_rr_arbiter: NUM_REQ must be a power of 2 >= 2 and MAX_HOLD >= 1");
  end

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   gnt_d, cand;
  logic [IDX_W-1:0]     idx_d, win;
  logic                 arb, found, release_owner, force_rotate;

`ifdef RPS_HOLD_TIMEOUT_EN
  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  logic [HOLD_W-1:0]    hold_q, hold_d;
`endif

  // First set bit of r scanning from p upward; index arithmetic wraps naturally.
  function automatic logic [IDX_W:0] pick(input logic [IDX_W-1:0] p, input logic [NUM_REQ-1:0] r);
    logic             hit;
    logic [IDX_W-1:0] idx, sel;
    hit = 1'b0;
    sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = p + IDX_W'(i);
      if (!hit && r[idx]) begin
        hit = 1'b1;
        sel = idx;
      end
    end
    return {hit, sel};
  endfunction

  assign req_up        = en & (|req);
  assign release_owner = (state_q == BUSY) && !req[gnt_idx];

`ifdef RPS_HOLD_TIMEOUT_EN
  assign force_rotate = (state_q == BUSY) && (hold_q == HOLD_W'(MAX_HOLD - 1)) && (|(req & ~gnt));
`else
  assign force_rotate = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt;
    idx_d   = gnt_idx;
    ptr_d   = ptr_q;
    arb     = 1'b0;
    cand    = req;
    if (!en) begin
      state_d = IDLE;
      gnt_d   = '0;
      idx_d   = '0;
    end else if (state_q == IDLE) begin
      arb = |req;
    end else if (release_owner || force_rotate) begin
      arb  = 1'b1;
      cand = req & ~gnt;
    end
    {found, win} = pick(ptr_q, cand);
    if (arb) begin
      if (found) begin
        state_d = BUSY;
        gnt_d   = NUM_REQ'(1) << win;
        idx_d   = win;
        ptr_d   = win + IDX_W'(1);
      end else begin
        state_d = IDLE;
        gnt_d   = '0;
        idx_d   = '0;
      end
    end
  end

`ifdef RPS_HOLD_TIMEOUT_EN
  // Counts held cycles; saturates so a lone owner keeps the grant.
  always_comb begin
    hold_d = hold_q;
    if (state_d == IDLE || (arb && found))
      hold_d = '0;
    else if (hold_q != HOLD_W'(MAX_HOLD - 1))
      hold_d = hold_q + HOLD_W'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) hold_q <= '0;
    else        hold_q <= hold_d;
  end
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt       <= gnt_d;
      gnt_idx   <= idx_d;
      gnt_valid <= |gnt_d;
    end
  end

endmodule

// File: tb/tb_rps_rr_arbiter.sv
// Directed bench for rps_rr_arbiter (NUM_REQ=4, MAX_HOLD=4); expectations are hand-derived per scenario.
module tb_rps_rr_arbiter;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       en    = 1'b0;
  logic [3:0] req   = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       req_up;

  int vectors = 0;
  int miscompares = 0;

  rps_rr_arbiter #(.NUM_REQ(4), .IDX_W(2), .MAX_HOLD(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .en       (en),
    .req      (req),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .gnt_valid(gnt_valid),
    .req_up   (req_up)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    en = 1'b1; req = 4'b1111; reset = 1'b0;
    tick(); tick();
    vectors++;
    if (gnt !== 4'b0000 || gnt_idx !== 2'd0 || gnt_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: gnt=%b idx=%0d vld=%b, want 0000/0/0", gnt, gnt_idx, gnt_valid);
    end
    vectors++;
    if (req_up !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_req_up: got %b want 1", req_up);
    end
    reset = 1'b1;
    tick();
    vectors++;
    if (gnt !== 4'b0001 || gnt_idx !== 2'd0 || gnt_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_first_grant: gnt=%b idx=%0d vld=%b, want 0001/0/1", gnt, gnt_idx, gnt_valid);
    end
  endtask

  task automatic test_hold_and_handoff();
    en = 1'b1; req = 4'b1010;
    do_reset();
    tick();
    vectors++;
    if (gnt !== 4'b0010 || gnt_idx !== 2'd1 || gnt_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL hold_first: gnt=%b idx=%0d vld=%b, want 0010/1/1", gnt, gnt_idx, gnt_valid);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      vectors++;
      if (gnt !== 4'b0010 || gnt_idx !== 2'd1) begin
        miscompares++;
        $display("FAIL hold_locked[%0d]: gnt=%b idx=%0d, want 0010/1", k, gnt, gnt_idx);
      end
    end
    req = 4'b1000;
    tick();
    vectors++;
    if (gnt !== 4'b1000 || gnt_idx !== 2'd3 || gnt_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL handoff_no_bubble: gnt=%b idx=%0d vld=%b, want 1000/3/1", gnt, gnt_idx, gnt_valid);
    end
  endtask

  task automatic test_rotation();
    logic [3:0] exp_gnt;
    en = 1'b1; req = 4'b1111;
    do_reset();
    tick();
    vectors++;
    if (gnt !== 4'b0001) begin
      miscompares++;
      $display("FAIL rotation_start: gnt=%b want 0001", gnt);
    end
    for (int k = 1; k <= 4; k++) begin
      req = 4'b1111 & ~gnt;
      exp_gnt = 4'b0001 << (k % 4);
      tick();
      vectors++;
      if (gnt !== exp_gnt || gnt_idx !== 2'(k % 4)) begin
        miscompares++;
        $display("FAIL rotation[%0d]: gnt=%b idx=%0d want %b/%0d", k, gnt, gnt_idx, exp_gnt, k % 4);
      end
    end
  endtask

  task automatic test_enable_drop();
    en = 1'b1; req = 4'b0100;
    do_reset();
    tick();
    vectors++;
    if (gnt !== 4'b0100) begin
      miscompares++;
      $display("FAIL enable_setup: gnt=%b want 0100", gnt);
    end
    en = 1'b0; req = 4'b1111;
    #1;
    vectors++;
    if (req_up !== 1'b0) begin
      miscompares++;
      $display("FAIL enable_req_up: got %b want 0", req_up);
    end
    tick();
    vectors++;
    if (gnt !== 4'b0000 || gnt_idx !== 2'd0 || gnt_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL enable_off: gnt=%b idx=%0d vld=%b, want 0000/0/0", gnt, gnt_idx, gnt_valid);
    end
    en = 1'b1;
    tick();
    vectors++;
    if (gnt !== 4'b1000 || gnt_idx !== 2'd3) begin
      miscompares++;
      $display("FAIL enable_ptr_kept: gnt=%b idx=%0d want 1000/3", gnt, gnt_idx);
    end
  endtask

  task automatic test_release_to_idle();
    en = 1'b1; req = 4'b0010;
    do_reset();
    tick();
    req = 4'b0000;
    tick();
    vectors++;
    if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || gnt_idx !== 2'd0) begin
      miscompares++;
      $display("FAIL release_idle: gnt=%b idx=%0d vld=%b, want 0000/0/0", gnt, gnt_idx, gnt_valid);
    end
    req = 4'b0001;
    tick();
    vectors++;
    if (gnt !== 4'b0001 || gnt_idx !== 2'd0 || gnt_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL release_regrant: gnt=%b idx=%0d vld=%b, want 0001/0/1", gnt, gnt_idx, gnt_valid);
    end
  endtask

  task automatic test_reset_mid_grant();
    en = 1'b1; req = 4'b1111;
    do_reset();
    tick();
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || gnt_idx !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_async: gnt=%b idx=%0d vld=%b, want 0000/0/0", gnt, gnt_idx, gnt_valid);
    end
    tick();
    reset = 1'b1;
    tick();
    vectors++;
    if (gnt !== 4'b0001) begin
      miscompares++;
      $display("FAIL reset_ptr_cleared: gnt=%b want 0001", gnt);
    end
  endtask

  task automatic test_hold_timeout();
    logic [3:0] exp_gnt;
    en = 1'b1; req = 4'b0011;
    do_reset();
    for (int k = 0; k < 16; k++) begin
      tick();
`ifdef RPS_HOLD_TIMEOUT_EN
      exp_gnt = ((k / 4) % 2 == 0) ? 4'b0001 : 4'b0010;
`else
      exp_gnt = 4'b0001;
`endif
      vectors++;
      if (gnt !== exp_gnt) begin
        miscompares++;
        $display("FAIL hold_timeout[%0d]: gnt=%b want %b", k, gnt, exp_gnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_hold_and_handoff();
    test_rotation();
    test_enable_drop();
    test_release_to_idle();
    test_reset_mid_grant();
    test_hold_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
